// File: rtl/shared_stage_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_stage_arbiter
// Description : Round-robin burst arbiter for a shared pipeline stage.
//               Optional starvation escalation when ARB_STARVE_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_stage_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         last,
  input  logic                       stall,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int                 c_ID_W    = $clog2(NUM_REQ);
  localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [c_ID_W:0]    c_NREQ    = (c_ID_W + 1)'(NUM_REQ);
  localparam logic [c_ID_W-1:0]  c_LAST_ID = c_ID_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [c_ID_W-1:0]    r_grant_id;
  logic [c_ID_W-1:0]    r_rr_ptr;
  logic [c_CNT_W-1:0]   r_beat_cnt;
  logic                 r_arb_ok;

  logic [NUM_REQ-1:0]   w_req_rot;
  logic                 w_rr_hit;
  logic [c_ID_W-1:0]    w_rr_off;
  logic [c_ID_W:0]      w_sum;
  logic [c_ID_W-1:0]    w_rr_idx;
  logic                 w_pick_hit;
  logic [c_ID_W-1:0]    w_pick_idx;
  logic                 w_beat;
  logic [c_CNT_W-1:0]   w_cnt_inc;
  logic                 w_release;
  logic [c_ID_W-1:0]    w_rr_next;

  // Rotate requests so bit 0 is rr_ptr, find the first hit, then un-rotate.
  assign w_req_rot = NUM_REQ'({req, req} >> r_rr_ptr);

  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_rr_hit = 1'b1;
        w_rr_off = c_ID_W'(k);
      end
    end
  end

  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_rr_off};
  assign w_rr_idx = (w_sum >= c_NREQ) ? c_ID_W'(w_sum - c_NREQ) : w_sum[c_ID_W-1:0];

`ifdef ARB_STARVE_PRIO_EN
  localparam int                  c_WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_WAIT_W-1:0] c_LIMIT  = c_WAIT_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0] w_sat;
  logic               w_sat_hit;
  logic [c_ID_W-1:0]  w_sat_idx;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_wait
    logic [c_WAIT_W-1:0] r_wait;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wait <= '0;
      end else if (!stall) begin
        if (!req[gi] || r_grant[gi]) begin
          r_wait <= '0;
        end else if (r_wait != c_LIMIT) begin
          r_wait <= r_wait + 1'b1;
        end
      end
    end
    assign w_sat[gi] = (r_wait == c_LIMIT);
  end

  always_comb begin
    w_sat_hit = |w_sat;
    w_sat_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_sat[k]) w_sat_idx = c_ID_W'(k);
    end
  end

  assign w_pick_hit = w_sat_hit | w_rr_hit;
  assign w_pick_idx = w_sat_hit ? w_sat_idx : w_rr_idx;
`else
  assign w_pick_hit = w_rr_hit;
  assign w_pick_idx = w_rr_idx;
`endif

  assign w_beat    = req[r_grant_id];
  assign w_cnt_inc = (r_beat_cnt == c_MAX) ? r_beat_cnt : r_beat_cnt + 1'b1;
  assign w_release = !w_beat || last[r_grant_id] || (w_cnt_inc == c_MAX);
  assign w_rr_next = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

  // r_arb_ok delays the first arbitration by one edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_arb_ok   <= 1'b0;
    end else begin
      r_arb_ok <= 1'b1;
      if (!stall) begin
        case (r_state)
          S_IDLE: begin
            if (r_arb_ok && w_pick_hit) begin
              r_state    <= S_LOCKED;
              r_grant    <= c_ONE << w_pick_idx;
              r_grant_id <= w_pick_idx;
              r_beat_cnt <= '0;
            end
          end
          S_LOCKED: begin
            if (w_release) begin
              r_state    <= S_IDLE;
              r_grant    <= '0;
              r_grant_id <= '0;
              r_beat_cnt <= '0;
              r_rr_ptr   <= w_rr_next;
            end else begin
              r_beat_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        endcase
      end
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: doc/shared_stage_arbiter.md
SHARED_STAGE_ARBITER -- requirements
Module: shared_stage_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (legal 2..8).
REQ-002 Parameter MAX_BURST, default 4, SHALL set the maximum beats per grant tenure (legal 1..15).
REQ-003 Parameter STARVE_LIMIT, default 8, SHALL set the wait-cycle threshold of the starvation feature (legal 1..255).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  SHALL carry per-requester request; bit i high = requester i wants the shared stage.
REQ-007 last  input  NUM_REQ  SHALL mark the final beat of requester i's transfer; sampled only for the granted requester.
REQ-008 stall  input  1  SHALL be the pipeline-wide global stall; high freezes the arbiter.
REQ-009 grant  output  NUM_REQ  SHALL be the registered, one-hot-or-zero grant vector.
REQ-010 grant_id  output  clog2(NUM_REQ)  SHALL be the binary index of the granted requester; 0 when grant is zero.
REQ-011 busy  output  1  SHALL be high exactly when grant is non-zero.

Function
REQ-012 The FSM SHALL have two states: IDLE (grant=0) and LOCKED (grant holds one winner).
REQ-013 In IDLE with stall=0 and req!=0, the winner SHALL be the first set req bit scanning upward from rr_ptr with wrap-around; on the next edge grant=onehot(winner), beat_cnt=0, state=LOCKED.
REQ-014 A LOCKED cycle with stall=0 and req[winner]=1 SHALL count as one beat; beat_cnt increments, saturating at MAX_BURST.
REQ-015 LOCKED SHALL release (IDLE on the next edge) on: a beat with last[winner]=1; a beat that brings beat_cnt to MAX_BURST; or stall=0 with req[winner]=0.
REQ-016 On release, rr_ptr SHALL become (winner+1) mod NUM_REQ and grant SHALL be 0 for at least one cycle (mandatory one-cycle bubble between tenures).
REQ-017 While stall=1, state, grant, grant_id, beat_cnt, rr_ptr and any wait counters SHALL hold; no arbitration and no release occur.
REQ-018 If stall and release conditions coincide, stall SHALL win; the release is evaluated again in the first cycle with stall=0.
REQ-019 Changes to req of non-granted requesters during LOCKED SHALL have no effect on grant.
REQ-020 grant SHALL never have more than one bit set in any cycle.
REQ-021 Grant latency from req assertion in IDLE with stall=0 SHALL be exactly one cycle.

Reset
REQ-022 reset_n low SHALL immediately (asynchronously) force grant=0, grant_id=0, busy=0, state=IDLE, beat_cnt=0, rr_ptr=0, wait counters=0.
REQ-023 Reset asserted mid-tenure SHALL abort the tenure with no release-cycle side effects; after deassertion the first arbitration starts from rr_ptr=0.
REQ-024 After reset_n rises, the first possible grant SHALL appear on the second rising edge following deassertion.

Configuration
REQ-025 Macro ARB_STARVE_PRIO_EN SHALL compile in starvation escalation.
REQ-026 With ARB_STARVE_PRIO_EN defined: per-requester wait counter increments each cycle with stall=0, req[i]=1, grant[i]=0; saturates at STARVE_LIMIT; clears when requester i is granted or req[i]=0.
REQ-027 With ARB_STARVE_PRIO_EN defined: in IDLE, if any counter equals STARVE_LIMIT, the lowest-index saturated requester SHALL win regardless of rr_ptr; rr_ptr update per REQ-016 is unchanged.
REQ-028 Without ARB_STARVE_PRIO_EN: no wait counters exist; arbitration is pure round-robin per REQ-013; ports and timing otherwise identical.

Verification
REQ-029 Reset, req=4'b0101 held, last=0, stall=0 -> grant 0001 for 4 beats, 0000 one cycle, then 0100 for 4 beats, 0000, then 0001 again.
REQ-030 req=4'b0010, last[1] high on 2nd beat -> grant 0010 for exactly 2 cycles, then 0000, rr_ptr=2.
REQ-031 Granted requester 0 at beat 1, stall=1 for 3 cycles with last[0]=1 -> grant 0001 held through stall, released after first unstalled beat.
REQ-032 reset_n pulsed low mid-tenure with grant=0100 -> grant 0000 same cycle (before next clk edge); after release req=4'b1100 -> grant 0100 (scan from 0).
REQ-033 ARB_STARVE_PRIO_EN, STARVE_LIMIT=2, MAX_BURST=1, req=4'b1111 continuously -> requester 3 granted no later than its counter saturating; no requester waits more than 2 unstalled non-granted cycles before priority.
REQ-034 Randomized req/last/stall for 10000 cycles -> grant always one-hot or zero, busy==|grant, no tenure exceeds MAX_BURST beats.
